// File: rtl/data_mem_pkg.sv
// Shared memory-map constants and helpers for the data-memory responder.
// Imported by the RTL and by anything that needs to address the MMIO window.
package data_mem_pkg;

    localparam int MMIO_SEL_BIT   = 29;
    localparam int MMIO_OFF_WIDTH = 4;

    typedef enum logic [MMIO_OFF_WIDTH-1:0] {
        MMIO_CYCLE_LO   = 4'd0,
        MMIO_CYCLE_HI   = 4'd1,
        MMIO_GPIO_OUT   = 4'd2,
        MMIO_HALT       = 4'd3,
        MMIO_TIMECMP_LO = 4'd4,
        MMIO_TIMECMP_HI = 4'd5
    } mmio_off_e;

    // Merge store data into an old word, byte lane n taken from new when mask[n].
    function automatic logic [31:0] apply_mask(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] r;
        r = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = new_word[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_if.sv
// Core-to-data-memory bus: word address, store data, write enable, byte mask, load data.
// master = core side, slave = memory responder.
interface data_mem_if;
    logic [29:0] i_mem_addr;
    logic [31:0] i_mem_data;
    logic        i_mem_we;
    logic [3:0]  i_mem_mask;
    logic [31:0] o_mem_data;

    modport master (
        output i_mem_addr,
        output i_mem_data,
        output i_mem_we,
        output i_mem_mask,
        input  o_mem_data
    );

    modport slave (
        input  i_mem_addr,
        input  i_mem_data,
        input  i_mem_we,
        input  i_mem_mask,
        output o_mem_data
    );
endinterface

// File: rtl/dmem_ram.sv
// Byte-maskable word RAM: combinational read, masked write on the rising edge.
// Contents are never reset; initial contents are undefined.
module dmem_ram #(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        mask,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Per-lane store; untouched lanes keep their old bytes
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we && mask[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem.sv
// Data-memory responder: RAM below the MMIO select bit, MMIO window above it.
// MMIO holds the cycle counter, timer compare/IRQ, GPIO output and halt/exit.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic         clk,
    input  logic         rst,
    data_mem_if.slave    bus,
    output logic [31:0]  o_gpio,
    output logic         o_timer_irq,
    output logic         o_halt,
    output logic [31:0]  o_exit_code
);

    logic        is_mmio;
    mmio_off_e   off;
    logic        wr;
    logic        ram_we;
    logic        mmio_we;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic [63:0] cycle;
    logic [63:0] timecmp;
    logic        unused_addr;

    assign is_mmio = bus.i_mem_addr[MMIO_SEL_BIT];
    assign off     = mmio_off_e'(bus.i_mem_addr[MMIO_OFF_WIDTH-1:0]);
    assign wr      = bus.i_mem_we && !o_halt;
    assign ram_we  = wr && !is_mmio;
    assign mmio_we = wr && is_mmio;

    // Upper word-address bits are don't-care: the RAM aliases through them
    assign unused_addr = ^bus.i_mem_addr[MMIO_SEL_BIT-1:ADDR_W];

    dmem_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .mask  (bus.i_mem_mask),
        .addr  (bus.i_mem_addr[ADDR_W-1:0]),
        .wdata (bus.i_mem_data),
        .rdata (ram_rdata)
    );

    // Free-running counter (frozen on halt) and registered timer compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle       <= '0;
            o_timer_irq <= 1'b0;
        end else begin
            o_timer_irq <= (cycle >= timecmp);
            if (!o_halt) cycle <= cycle + 64'd1;
        end
    end

    // Writable MMIO registers; halt latches the full store word as exit code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_gpio      <= '0;
            o_halt      <= 1'b0;
            o_exit_code <= '0;
            timecmp     <= '1;
        end else if (mmio_we) begin
            case (off)
                MMIO_GPIO_OUT:
                    o_gpio <= apply_mask(o_gpio, bus.i_mem_data, bus.i_mem_mask);
                MMIO_HALT:
                    if (|bus.i_mem_mask) begin
                        o_halt      <= 1'b1;
                        o_exit_code <= bus.i_mem_data;
                    end
                MMIO_TIMECMP_LO:
                    timecmp[31:0] <= apply_mask(timecmp[31:0], bus.i_mem_data,
                                                bus.i_mem_mask);
                MMIO_TIMECMP_HI:
                    timecmp[63:32] <= apply_mask(timecmp[63:32], bus.i_mem_data,
                                                 bus.i_mem_mask);
                default: ;
            endcase
        end
    end

    // MMIO read mux; HALT and unmapped offsets read as zero
    always_comb begin
        mmio_rdata = '0;
        case (off)
            MMIO_CYCLE_LO:   mmio_rdata = cycle[31:0];
            MMIO_CYCLE_HI:   mmio_rdata = cycle[63:32];
            MMIO_GPIO_OUT:   mmio_rdata = o_gpio;
            MMIO_TIMECMP_LO: mmio_rdata = timecmp[31:0];
            MMIO_TIMECMP_HI: mmio_rdata = timecmp[63:32];
            default:         mmio_rdata = '0;
        endcase
    end

    assign bus.o_mem_data = is_mmio ? mmio_rdata : ram_rdata;

endmodule

// File: tb/tb_data_mem.sv
// Randomised bench for data_mem against a word/register-level reference model.
// Directed sections cover masking, aliasing, timer, counter carry, halt and reset.
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio;
    logic        irq;
    logic        halt;
    logic [31:0] exit_code;

    data_mem_if bus ();

    data_mem #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_gpio      (gpio),
        .o_timer_irq (irq),
        .o_halt      (halt),
        .o_exit_code (exit_code)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] m_ram [int];
    logic [63:0] m_cyc;
    logic [63:0] m_tcmp;
    logic [31:0] m_gpio;
    logic [31:0] m_exit;
    logic        m_halt;
    logic        m_irq;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [29:0] mm(input int o);
        return {1'b1, 25'd0, 4'(o)};
    endfunction

    function automatic logic [29:0] ra(input int idx, input int upper);
        return {1'b0, 19'(upper), 10'(idx)};
    endfunction

    function automatic logic [31:0] m_read(input logic [29:0] a);
        if (!a[29]) return m_ram[int'(a[ADDR_W-1:0])];
        case (int'(a[3:0]))
            0: return m_cyc[31:0];
            1: return m_cyc[63:32];
            2: return m_gpio;
            4: return m_tcmp[31:0];
            5: return m_tcmp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_cyc  = '0;
        m_tcmp = '1;
        m_gpio = '0;
        m_exit = '0;
        m_halt = 1'b0;
        m_irq  = 1'b0;
    endtask

    // Reference behaviour of one rising edge, given the inputs on the bus
    task automatic model_edge();
        logic [29:0] a;
        int idx;
        a = bus.i_mem_addr;
        m_irq = (m_cyc >= m_tcmp);
        if (!m_halt) begin
            if (bus.i_mem_we) begin
                if (!a[29]) begin
                    idx = int'(a[ADDR_W-1:0]);
                    if (!m_ram.exists(idx)) m_ram[idx] = '0;
                    m_ram[idx] = merge(m_ram[idx], bus.i_mem_data, bus.i_mem_mask);
                end else begin
                    case (int'(a[3:0]))
                        2: m_gpio = merge(m_gpio, bus.i_mem_data, bus.i_mem_mask);
                        3: if (bus.i_mem_mask != 4'd0) begin
                               m_halt = 1'b1;
                               m_exit = bus.i_mem_data;
                           end
                        4: m_tcmp[31:0] = merge(m_tcmp[31:0], bus.i_mem_data,
                                                bus.i_mem_mask);
                        5: m_tcmp[63:32] = merge(m_tcmp[63:32], bus.i_mem_data,
                                                 bus.i_mem_mask);
                        default: ;
                    endcase
                end
            end
            m_cyc = m_cyc + 64'd1;
        end
    endtask

    task automatic drive(input logic [29:0] a, input logic [31:0] d,
                         input logic we, input logic [3:0] m);
        bus.i_mem_addr = a;
        bus.i_mem_data = d;
        bus.i_mem_we   = we;
        bus.i_mem_mask = m;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("gpio", 64'(gpio), 64'(m_gpio));
        check("irq", 64'(irq), 64'(m_irq));
        check("halt", 64'(halt), 64'(m_halt));
        check("exit", 64'(exit_code), 64'(m_exit));
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        drive(a, d, 1'b1, m);
        step();
        drive(a, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic rd(input string tag, input logic [29:0] a,
                      input logic [31:0] exp);
        drive(a, 32'd0, 1'b0, 4'd0);
        #1;
        check(tag, 64'(bus.o_mem_data), 64'(exp));
    endtask

    initial begin
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        we;
        int          kind;
        int          rise_cyc;
        int          guard;

        rst = 1'b1;
        model_reset();
        drive(mm(0), 32'd0, 1'b0, 4'd0);
        #1;
        check("rst_gpio", 64'(gpio), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_halt", 64'(halt), 64'd0);
        check("rst_exit", 64'(exit_code), 64'd0);
        rd("rst_cyc_lo", mm(0), 32'd0);
        rd("rst_tcmp_lo", mm(4), 32'hFFFF_FFFF);
        rd("rst_tcmp_hi", mm(5), 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Timer: compare at 50, then raise it to 1000
        wr(mm(5), 32'd0, 4'hF);
        wr(mm(4), 32'd50, 4'hF);
        rise_cyc = -1;
        guard = 0;
        while (m_cyc < 64'd60 && guard < 200) begin
            step();
            if (irq && rise_cyc < 0) rise_cyc = int'(m_cyc);
            guard++;
        end
        check("irq_rise_cycle", 64'(rise_cyc), 64'd51);

        // RAM masking and aliasing
        wr(ra(5, 0), 32'hDEAD_BEEF, 4'hF);
        wr(ra(5, 0), 32'h0000_00AA, 4'h1);
        rd("ram_mask", ra(5, 0), 32'hDEAD_BEAA);
        wr(ra(5, 0), 32'h0000_0000, 4'h0);
        rd("ram_mask0", ra(5, 0), 32'hDEAD_BEAA);
        wr(ra(3, 0), 32'h1234_5678, 4'hF);
        rd("ram_alias", ra(3, 1), 32'h1234_5678);

        guard = 0;
        while (m_cyc < 64'd100 && guard < 200) begin
            step();
            guard++;
        end
        rd("cyc_lo_100", mm(0), 32'd100);
        rd("cyc_hi_100", mm(1), 32'd0);
        wr(mm(4), 32'd1000, 4'hF);
        check("irq_hold", 64'(irq), 64'd1);
        step();
        check("irq_drop", 64'(irq), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 16; i++)
            wr(ra(i, int'($urandom)), $urandom, 4'hF);
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            d  = $urandom;
            m  = 4'($urandom);
            we = 1'($urandom);
            if (kind < 6) begin
                a = ra(int'($urandom_range(0, 15)), int'($urandom));
            end else begin
                a = mm(int'($urandom_range(0, 15)));
                if (kind == 6) a = mm(int'($urandom_range(4, 5)));
                if (kind == 7) a = mm(2);
                if (a[3:0] == 4'd3) we = 1'b0;
            end
            drive(a, d, we, m);
            #1;
            check("rand_rd", 64'(bus.o_mem_data), 64'(m_read(a)));
            step();
        end
        drive(mm(0), 32'd0, 1'b0, 4'd0);

        // Counter carry into the high word
        wr(mm(4), 32'hFFFF_FFFF, 4'hF);
        wr(mm(5), 32'hFFFF_FFFF, 4'hF);
        force dut.cycle = 64'h0000_0000_FFFF_FFF8;
        #1;
        release dut.cycle;
        m_cyc = 64'h0000_0000_FFFF_FFF8;
        repeat (16) step();
        rd("carry_lo", mm(0), 32'h0000_0008);
        rd("carry_hi", mm(1), 32'h0000_0001);

        // Halt behaviour
        wr(ra(200, 0), 32'hCAFE_F00D, 4'hF);
        wr(mm(2), 32'h5, 4'hF);
        wr(mm(3), 32'h2A, 4'h1);
        check("halt_set", 64'(halt), 64'd1);
        check("exit_code", 64'(exit_code), 64'h2A);
        wr(ra(200, 0), 32'h1111_1111, 4'hF);
        wr(mm(2), 32'h77, 4'hF);
        wr(mm(3), 32'h99, 4'hF);
        check("halt_gpio", 64'(gpio), 64'h5);
        check("halt_exit", 64'(exit_code), 64'h2A);
        rd("halt_ram", ra(200, 0), 32'hCAFE_F00D);
        d = m_cyc[31:0];
        repeat (5) step();
        rd("halt_frozen", mm(0), d);

        // Asynchronous reset between edges while halted
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_halt", 64'(halt), 64'd0);
        check("arst_gpio", 64'(gpio), 64'd0);
        check("arst_exit", 64'(exit_code), 64'd0);
        check("arst_irq", 64'(irq), 64'd0);
        rd("arst_tcmp_lo", mm(4), 32'hFFFF_FFFF);
        rd("arst_tcmp_hi", mm(5), 32'hFFFF_FFFF);
        rd("arst_ram", ra(200, 0), 32'hCAFE_F00D);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) step();
        rd("post_rst_cyc", mm(0), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
